// File: rtl/game_tick_scheduler_pkg.sv
// game_tick_pkg: shared run-state type, default sizing and counter-width helper
// for the snake-game tick scheduler.
package game_tick_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } run_state_e;

  // Bits needed to count 0..period-1 (never less than one bit).
  function automatic int cnt_w(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

  localparam int CLK_HZ_DEF          = 100000000;
  localparam int BASE_HZ_DEF         = 1000;
  localparam int NUM_LEVELS_DEF      = 8;
  localparam int STEP_MS_SLOWEST_DEF = 400;
  localparam int STEP_MS_DEC_DEF     = 40;
  localparam int REFRESH_MS_DEF      = 25;
  localparam int BLINK_MS_DEF        = 250;
  localparam int AUTO_STEPS_DEF      = 32;

  localparam int LEVEL_W    = cnt_w(NUM_LEVELS_DEF);
  localparam int PRESCALE   = CLK_HZ_DEF / BASE_HZ_DEF;
  localparam int PRESCALE_W = cnt_w(PRESCALE);
  localparam int STEP_W     = cnt_w(STEP_MS_SLOWEST_DEF);
  localparam int REFRESH_W  = cnt_w(REFRESH_MS_DEF);
  localparam int BLINK_W    = cnt_w(BLINK_MS_DEF);

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Control/status bundle between the game logic (master) and the tick
// scheduler (slave).
interface game_tick_scheduler_if
  import game_tick_pkg::*;
#(
  parameter int LVL_W = game_tick_pkg::LEVEL_W
) ();

  logic             start;
  logic             stop;
  logic             pause_toggle;
  logic             speed_up;
  logic             step_ready;
  logic             step_valid;
  logic             refresh_tick;
  logic             blink_state;
  logic [LVL_W-1:0] level;
  run_state_e       run_state;
  logic             overrun;

  modport master (
    output start, stop, pause_toggle, speed_up, step_ready,
    input  step_valid, refresh_tick, blink_state, level, run_state, overrun
  );

  modport slave (
    input  start, stop, pause_toggle, speed_up, step_ready,
    output step_valid, refresh_tick, blink_state, level, run_state, overrun
  );

endinterface

// File: rtl/game_tick_scheduler_tick_divider.sv
// tick_divider: counts enable pulses 0..PERIOD-1 and flags the terminal count
// combinationally in the same cycle as the enable that reaches it.
module tick_divider
  import game_tick_pkg::*;
#(
  parameter int PERIOD = 10
) (
  input  logic clk100Mhz,
  input  logic rst,
  input  logic en,
  output logic pulse
);

  localparam int CW = cnt_w(PERIOD);
  localparam logic [CW-1:0] TERM = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_r;

  assign pulse = en && (cnt_r == TERM);

  // wrap-around counter advanced by en
  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (pulse) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: 1 ms prescaler, step/refresh/blink strobes and game run state.
// Optional automatic speed-up after AUTO_STEPS accepted steps: GAME_TICK_AUTO_SPEEDUP_EN.
module game_tick_scheduler
  import game_tick_pkg::*;
#(
  parameter int CLK_HZ          = CLK_HZ_DEF,
  parameter int BASE_HZ         = BASE_HZ_DEF,
  parameter int NUM_LEVELS      = NUM_LEVELS_DEF,
  parameter int STEP_MS_SLOWEST = STEP_MS_SLOWEST_DEF,
  parameter int STEP_MS_DEC     = STEP_MS_DEC_DEF,
  parameter int REFRESH_MS      = REFRESH_MS_DEF,
  parameter int BLINK_MS        = BLINK_MS_DEF,
  parameter int AUTO_STEPS      = AUTO_STEPS_DEF
) (
  input logic                  clk100Mhz,
  input logic                  rst,
  game_tick_scheduler_if.slave bus
);

  localparam int P_CLKS  = CLK_HZ / BASE_HZ;
  localparam int LVL_W   = cnt_w(NUM_LEVELS);
  localparam int STEP_CW = cnt_w(STEP_MS_SLOWEST);
  localparam logic [LVL_W-1:0] LEVEL_MAX = LVL_W'(NUM_LEVELS - 1);

  if ((STEP_MS_SLOWEST <= (NUM_LEVELS - 1) * STEP_MS_DEC) || (AUTO_STEPS < 1)) begin : g_bad_cfg
    $error("game_tick_scheduler: step period must stay positive at every level");
  end

  logic               ms_tick_s;
  logic               refresh_term_s;
  logic               blink_term_s;
  logic               refresh_tick_r;
  logic               blink_r;
  run_state_e         state_r;
  run_state_e         state_nxt_s;
  logic [LVL_W-1:0]   level_r;
  logic [LVL_W-1:0]   level_nxt_s;
  logic [STEP_CW-1:0] step_cnt_r;
  logic [STEP_CW-1:0] step_cnt_nxt_s;
  logic               pending_r;
  logic               pending_nxt_s;
  logic               overrun_r;
  logic               overrun_nxt_s;
  logic               step_valid_r;
  logic [31:0]        period_s;
  logic               fire_s;
  logic               accept_s;
  logic               auto_inc_s;
  logic               inc_s;

  tick_divider #(.PERIOD(P_CLKS)) u_prescale (
    .clk100Mhz (clk100Mhz),
    .rst       (rst),
    .en        (1'b1),
    .pulse     (ms_tick_s)
  );

  tick_divider #(.PERIOD(REFRESH_MS)) u_refresh (
    .clk100Mhz (clk100Mhz),
    .rst       (rst),
    .en        (ms_tick_s),
    .pulse     (refresh_term_s)
  );

  tick_divider #(.PERIOD(BLINK_MS)) u_blink (
    .clk100Mhz (clk100Mhz),
    .rst       (rst),
    .en        (ms_tick_s),
    .pulse     (blink_term_s)
  );

  // refresh strobe and blink square wave
  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      refresh_tick_r <= 1'b0;
      blink_r        <= 1'b0;
    end else begin
      refresh_tick_r <= refresh_term_s;
      blink_r        <= blink_term_s ? ~blink_r : blink_r;
    end
  end

`ifdef GAME_TICK_AUTO_SPEEDUP_EN
  localparam int AUTO_W = cnt_w(AUTO_STEPS);
  localparam logic [AUTO_W-1:0] AUTO_TERM = AUTO_W'(AUTO_STEPS - 1);

  logic [AUTO_W-1:0] auto_cnt_r;

  assign auto_inc_s = accept_s && (auto_cnt_r == AUTO_TERM) && !bus.start && !bus.stop;

  // accepted-step counter behind the automatic level increase
  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      auto_cnt_r <= '0;
    end else if (bus.start || bus.stop) begin
      auto_cnt_r <= '0;
    end else if (auto_inc_s) begin
      auto_cnt_r <= '0;
    end else if (accept_s) begin
      auto_cnt_r <= auto_cnt_r + AUTO_W'(1);
    end else begin
      auto_cnt_r <= auto_cnt_r;
    end
  end
`else
  assign auto_inc_s = 1'b0;
`endif

  assign inc_s = bus.speed_up || auto_inc_s;

  // next state, step channel and level; stop > start > pause_toggle
  always_comb begin
    period_s = 32'(STEP_MS_SLOWEST) - (32'(level_r) * 32'(STEP_MS_DEC));
    fire_s   = ms_tick_s && (state_r == RUN) && (32'(step_cnt_r) >= (period_s - 32'd1));
    accept_s = step_valid_r && bus.step_ready;

    state_nxt_s    = state_r;
    step_cnt_nxt_s = step_cnt_r;
    pending_nxt_s  = pending_r;
    overrun_nxt_s  = overrun_r;
    level_nxt_s    = level_r;

    if (bus.stop) begin
      state_nxt_s = IDLE;
    end else if (bus.start) begin
      state_nxt_s = RUN;
    end else if (bus.pause_toggle) begin
      case (state_r)
        RUN:     state_nxt_s = PAUSED;
        PAUSED:  state_nxt_s = RUN;
        IDLE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end

    if (bus.stop || bus.start) begin
      step_cnt_nxt_s = '0;
      pending_nxt_s  = 1'b0;
      overrun_nxt_s  = 1'b0;
    end else begin
      if (fire_s) begin
        step_cnt_nxt_s = '0;
      end else if (ms_tick_s && (state_r == RUN)) begin
        step_cnt_nxt_s = step_cnt_r + STEP_CW'(1);
      end else begin
        step_cnt_nxt_s = step_cnt_r;
      end
      // a fire racing an accept replaces the step rather than overrunning it
      if (fire_s) begin
        pending_nxt_s = 1'b1;
        overrun_nxt_s = overrun_r || (pending_r && !accept_s);
      end else if (accept_s) begin
        pending_nxt_s = 1'b0;
        overrun_nxt_s = overrun_r;
      end else begin
        pending_nxt_s = pending_r;
        overrun_nxt_s = overrun_r;
      end
    end

    if (bus.start && !bus.stop) begin
      level_nxt_s = '0;
    end else if (inc_s && (level_r != LEVEL_MAX)) begin
      level_nxt_s = level_r + LVL_W'(1);
    end else begin
      level_nxt_s = level_r;
    end
  end

  // state, step channel and level registers
  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      state_r      <= IDLE;
      step_cnt_r   <= '0;
      pending_r    <= 1'b0;
      overrun_r    <= 1'b0;
      level_r      <= '0;
      step_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      step_cnt_r   <= step_cnt_nxt_s;
      pending_r    <= pending_nxt_s;
      overrun_r    <= overrun_nxt_s;
      level_r      <= level_nxt_s;
      step_valid_r <= pending_nxt_s && (state_nxt_s == RUN);
    end
  end

  assign bus.step_valid   = step_valid_r;
  assign bus.refresh_tick = refresh_tick_r;
  assign bus.blink_state  = blink_r;
  assign bus.level        = level_r;
  assign bus.run_state    = state_r;
  assign bus.overrun      = overrun_r;

endmodule
